add_mul_pp_accu_seq: RTL and testbench

- Sequential partial-product accumulator; sits directly downstream of the adder-multiplier partial-product generator and turns its row vector PP into the final product P.
- Reduction happens over several cycles:
  - Folds RowsPerCycle rows per cycle into registered carry-save sum/carry words using a 3:2 compressor chain.
  - Finishes with one carry-propagate add cycle.
- Valid/ready handshake on both sides, so it trades area against the full combinational Braun array.

---
 rtl/add_mul_pp_accu_seq.sv | 148 ++++++++++++++
 tb/tb_add_mul_pp_accu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_mul_pp_accu_seq.sv
// Sequential partial-product accumulator: folds RowsPerCycle PP rows per cycle into
// carry-save S/C registers, then resolves P with a single carry-propagate add.
module add_mul_pp_accu_seq #(
    parameter int widthX       = 8,
    parameter int widthY       = 8,
    parameter int RowsPerCycle = 2
) (
    input  logic                                         CLK,
    input  logic                                         RST,
    input  logic                                         FLUSH,
    input  logic                                         IN_VALID,
    output logic                                         IN_READY,
    input  logic [(widthX+1)*(widthX+widthY)-1:0]        PP,
    output logic                                         OUT_VALID,
    input  logic                                         OUT_READY,
    output logic [widthX+widthY-1:0]                     P,
    output logic                                         BUSY
);

    localparam int widthP = widthX + widthY;
    localparam int R      = widthX + 1;
    localparam int K      = RowsPerCycle;
    localparam int N      = (R + K - 1) / K;
    // Row buffer is padded to N*K rows so rows past R read as zero.
    localparam int BW     = N * K * widthP;
    localparam int CW     = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACCU = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [widthP-1:0]   s_q, s_d;
    logic [widthP-1:0]   c_q, c_d;
    logic [BW-1:0]       rows_q, rows_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [widthP-1:0]   p_q, p_d;

    logic [widthP-1:0]   chain_s [0:K];
    logic [widthP-1:0]   chain_c [0:K];

    function automatic logic [widthP-1:0] csa_sum(input logic [widthP-1:0] a,
                                                  input logic [widthP-1:0] b,
                                                  input logic [widthP-1:0] c);
        return a ^ b ^ c;
    endfunction

    // Majority carry moves up one weight; the bit leaving the top is dropped (mod 2^widthP).
    function automatic logic [widthP-1:0] csa_carry(input logic [widthP-1:0] a,
                                                    input logic [widthP-1:0] b,
                                                    input logic [widthP-1:0] c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    // K chained 3:2 stages over the lowest K rows of the buffer.
    always_comb begin
        chain_s[0] = s_q;
        chain_c[0] = c_q;
        for (int k = 0; k < K; k++) begin
            chain_s[k+1] = csa_sum(chain_s[k], chain_c[k], rows_q[k*widthP +: widthP]);
            chain_c[k+1] = csa_carry(chain_s[k], chain_c[k], rows_q[k*widthP +: widthP]);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        rows_d  = rows_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        if (FLUSH) begin
            state_d = ST_IDLE;
            s_d     = {widthP{1'b0}};
            c_d     = {widthP{1'b0}};
            cnt_d   = {CW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        rows_d  = BW'(PP);
                        s_d     = {widthP{1'b0}};
                        c_d     = {widthP{1'b0}};
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_ACCU;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACCU: begin
                    s_d    = chain_s[K];
                    c_d    = chain_c[K];
                    rows_d = rows_q >> (K * widthP);
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_ADD;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ST_ACCU;
                    end
                end
                ST_ADD: begin
                    p_d     = s_q + c_q;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            s_q     <= {widthP{1'b0}};
            c_q     <= {widthP{1'b0}};
            rows_q  <= {BW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            p_q     <= {widthP{1'b0}};
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            rows_q  <= rows_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_DONE);
    assign BUSY      = (state_q != ST_IDLE);
    assign P         = p_q;

endmodule

// File: tb/tb_add_mul_pp_accu_seq.sv
// Bench for add_mul_pp_accu_seq: directed 4x4 checks on K=2/1/5 and a random 8x8 stream
// on K=1/2/3/9, each instance with its own expected-result queue.
module tb_add_mul_pp_accu_seq;

    logic         clk = 1'b0;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    logic         rst_a, flush_a, inv_a, ordy_a;
    logic [39:0]  pp_a;
    logic         rst_b, flush_b, inv_b, ordy_b;
    logic [143:0] pp_b;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] sum4(input logic [39:0] pp);
        logic [7:0] s;
        s = 8'd0;
        for (int r = 0; r < 5; r++) s = s + pp[r*8 +: 8];
        return s;
    endfunction

    function automatic logic [15:0] sum8(input logic [143:0] pp);
        logic [15:0] s;
        s = 16'd0;
        for (int r = 0; r < 9; r++) s = s + pp[r*16 +: 16];
        return s;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g4
        localparam int K = (gi == 0) ? 2 : ((gi == 1) ? 1 : 5);
        localparam int N = (5 + K - 1) / K;
        logic        rdy_s, ov_s, busy_s;
        logic [7:0]  p_s;
        logic [7:0]  exp_q [$];
        int          acc_cyc = 0;
        logic        ov_prev = 1'b0;

        add_mul_pp_accu_seq #(.widthX(4), .widthY(4), .RowsPerCycle(K)) u_dut (
            .CLK(clk), .RST(rst_a), .FLUSH(flush_a), .IN_VALID(inv_a), .IN_READY(rdy_s),
            .PP(pp_a), .OUT_VALID(ov_s), .OUT_READY(ordy_a), .P(p_s), .BUSY(busy_s)
        );

        always @(negedge clk) begin
            if (rst_a) begin
                exp_q.delete();
                ov_prev <= 1'b0;
            end else begin
                if (ov_s && !ov_prev) check($sformatf("lat4_k%0d", K), 32'(cyc - acc_cyc), 32'(N + 2));
                if (ov_s && ordy_a && !flush_a) begin
                    check($sformatf("outq4_k%0d", K), 32'(exp_q.size()), 32'd1);
                    if (exp_q.size() != 0) check($sformatf("p4_k%0d", K), 32'(p_s), 32'(exp_q.pop_front()));
                end
                if (flush_a) exp_q.delete();
                if (inv_a && rdy_s && !flush_a) begin
                    exp_q.push_back(sum4(pp_a));
                    acc_cyc <= cyc;
                end
                ov_prev <= ov_s;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g8
        localparam int K = (gi == 0) ? 1 : ((gi == 1) ? 2 : ((gi == 2) ? 3 : 9));
        localparam int N = (9 + K - 1) / K;
        logic        rdy_s, ov_s, busy_s;
        logic [15:0] p_s;
        logic [15:0] exp_q [$];
        int          acc_cyc = 0;
        int          n_out = 0;
        logic        ov_prev = 1'b0;

        add_mul_pp_accu_seq #(.widthX(8), .widthY(8), .RowsPerCycle(K)) u_dut (
            .CLK(clk), .RST(rst_b), .FLUSH(flush_b), .IN_VALID(inv_b), .IN_READY(rdy_s),
            .PP(pp_b), .OUT_VALID(ov_s), .OUT_READY(ordy_b), .P(p_s), .BUSY(busy_s)
        );

        always @(negedge clk) begin
            if (rst_b) begin
                exp_q.delete();
                ov_prev <= 1'b0;
            end else begin
                if (ov_s && !ov_prev) check($sformatf("lat8_k%0d", K), 32'(cyc - acc_cyc), 32'(N + 2));
                if (ov_s && ordy_b && !flush_b) begin
                    check($sformatf("outq8_k%0d", K), 32'(exp_q.size()), 32'd1);
                    if (exp_q.size() != 0) check($sformatf("p8_k%0d", K), 32'(p_s), 32'(exp_q.pop_front()));
                    n_out <= n_out + 1;
                end
                if (flush_b) exp_q.delete();
                if (inv_b && rdy_s && !flush_b) begin
                    exp_q.push_back(sum8(pp_b));
                    acc_cyc <= cyc;
                end
                ov_prev <= ov_s;
            end
        end
    end

    task automatic wait_all4_done();
        for (int i = 0; i < 40 && !(g4[0].ov_s && g4[1].ov_s && g4[2].ov_s); i++) begin
            @(posedge clk);
            #1;
        end
        check("done4_timeout", 32'(g4[0].ov_s && g4[1].ov_s && g4[2].ov_s), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1; flush_a = 1'b0; inv_a = 1'b0; ordy_a = 1'b0; pp_a = 40'd0;
        rst_b = 1'b1; flush_b = 1'b0; inv_b = 1'b0; ordy_b = 1'b0; pp_b = 144'd0;
        #2;
        check("rst_p",    32'(g4[0].p_s),    32'd0);
        check("rst_ov",   32'(g4[0].ov_s),   32'd0);
        check("rst_rdy",  32'(g4[0].rdy_s),  32'd1);
        check("rst_busy", 32'(g4[0].busy_s), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // saturating rows: 5 x 0xFF
        pp_a = {5{8'hFF}}; inv_a = 1'b1; ordy_a = 1'b1;
        @(posedge clk); #1; inv_a = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("sat_p_k2", 32'(g4[0].p_s), 32'h0000_00FB);
        check("sat_p_k1", 32'(g4[1].p_s), 32'h0000_00FB);
        check("sat_p_k5", 32'(g4[2].p_s), 32'h0000_00FB);

        // signed 5 * -3: rows Y<<0 and Y<<2 with Y = 0xFD
        ordy_a = 1'b0;
        pp_a = {8'h00, 8'h00, 8'hF4, 8'h00, 8'hFD}; inv_a = 1'b1;
        @(posedge clk); #1; inv_a = 1'b0;
        wait_all4_done();
        check("sgn_p_k2", 32'(g4[0].p_s), 32'h0000_00F1);
        check("sgn_p_k1", 32'(g4[1].p_s), 32'h0000_00F1);
        check("sgn_p_k5", 32'(g4[2].p_s), 32'h0000_00F1);

        // backpressure with IN_VALID held high
        pp_a = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; inv_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_p",   32'(g4[0].p_s),   32'h0000_00F1);
            check("bp_ov",  32'(g4[0].ov_s),  32'd1);
            check("bp_rdy", 32'(g4[0].rdy_s), 32'd0);
            check("bp_rdy_k1", 32'(g4[1].rdy_s), 32'd0);
        end
        ordy_a = 1'b1;
        @(posedge clk); #1; ordy_a = 1'b0;
        check("bp_idle_rdy",  32'(g4[0].rdy_s),  32'd1);
        check("bp_idle_busy", 32'(g4[0].busy_s), 32'd0);
        @(posedge clk); #1; inv_a = 1'b0;
        check("bp_accept_busy", 32'(g4[0].busy_s), 32'd1);
        ordy_a = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("bp_new_p", 32'(g4[0].p_s), 32'h0000_000F);

        // FLUSH in the second ACCU cycle
        pp_a = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}; inv_a = 1'b1;
        @(posedge clk); #1; inv_a = 1'b0;
        @(posedge clk); #1; flush_a = 1'b1;
        @(posedge clk); #1; flush_a = 1'b0;
        check("fl_busy",    32'(g4[0].busy_s), 32'd0);
        check("fl_busy_k1", 32'(g4[1].busy_s), 32'd0);
        check("fl_ov",      32'(g4[0].ov_s),   32'd0);
        check("fl_rdy",     32'(g4[0].rdy_s),  32'd1);
        check("fl_p",       32'(g4[0].p_s),    32'h0000_000F);
        repeat (8) @(posedge clk);
        #1;
        check("fl_no_ov", 32'(g4[0].ov_s || g4[1].ov_s || g4[2].ov_s), 32'd0);
        check("fl_p_k5",  32'(g4[2].p_s), 32'h0000_000F);

        // FLUSH together with IN_VALID in IDLE
        flush_a = 1'b1; inv_a = 1'b1;
        #1;
        check("fliv_rdy", 32'(g4[0].rdy_s), 32'd1);
        @(posedge clk); #1;
        check("fliv_busy", 32'(g4[0].busy_s), 32'd0);
        flush_a = 1'b0; inv_a = 1'b0;

        // asynchronous reset mid-ACCU, then a fresh operation
        pp_a = {5{8'd1}}; inv_a = 1'b1;
        @(posedge clk); #1; inv_a = 1'b0;
        @(posedge clk); #2; rst_a = 1'b1;
        #1;
        check("arst_p",    32'(g4[0].p_s),    32'd0);
        check("arst_ov",   32'(g4[0].ov_s),   32'd0);
        check("arst_rdy",  32'(g4[0].rdy_s),  32'd1);
        check("arst_busy", 32'(g4[0].busy_s), 32'd0);
        @(posedge clk); @(posedge clk); #1; rst_a = 1'b0;
        pp_a = {8'd7, 8'd9, 8'd11, 8'd13, 8'd200}; inv_a = 1'b1;
        @(posedge clk); #1; inv_a = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("arst_fresh_p", 32'(g4[0].p_s), 32'h0000_00F0);
        check("q4_k2_empty", 32'(g4[0].exp_q.size()), 32'd0);
        check("q4_k1_empty", 32'(g4[1].exp_q.size()), 32'd0);
        check("q4_k5_empty", 32'(g4[2].exp_q.size()), 32'd0);

        // random 8x8 stream with random backpressure
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            inv_b = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 9; r++) pp_b[r*16 +: 16] = 16'($urandom);
            ordy_b = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        inv_b = 1'b0; ordy_b = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("q8_k1_empty", 32'(g8[0].exp_q.size()), 32'd0);
        check("q8_k2_empty", 32'(g8[1].exp_q.size()), 32'd0);
        check("q8_k3_empty", 32'(g8[2].exp_q.size()), 32'd0);
        check("q8_k9_empty", 32'(g8[3].exp_q.size()), 32'd0);
        check("n8_k1_active", 32'(g8[0].n_out > 500), 32'd1);
        check("n8_k9_active", 32'(g8[3].n_out > 1500), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
